// File: rtl/whack_hit_scorer.sv
// -----------------------------------------------------------------------------
// whack_hit_scorer
//
// Hit-qualification and scoring stage for the whack-a-box game. The raw
// struck-box code from the sensor bus is synchronised and debounced. Each
// rising strike (debounced code going from 0 to nonzero) becomes one event.
// The event is compared against the current target box and a saturating
// score is kept. Single-cycle pulses are emitted to trigger audio and to
// advance the target LFSR.
//
// Ports
//   CLOCK_50     in   1        system clock, all logic on the rising edge
//   resetn       in   1        synchronous, active-low reset
//   game_active  in   1        high while a round runs; rising edge clears score
//   sensor_addr  in   3        asynchronous struck-box code, 0 = nothing struck
//   target_addr  in   3        current target box, 0 = no target
//   score        out  SCORE_W  running score (unsigned, saturating)
//   hit_pulse    out  1        one-cycle pulse on a correct strike
//   miss_pulse   out  1        one-cycle pulse on a wrong strike
//   next_target  out  1        one-cycle pulse with hit_pulse, requests new target
//   armed        out  1        high while a strike can be scored
// -----------------------------------------------------------------------------
module whack_hit_scorer #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int COOLDOWN_CYCLES = 12500000,
   parameter int SCORE_W         = 11
) (
   input  logic               CLOCK_50,
   input  logic               resetn,
   input  logic               game_active,
   input  logic [2:0]         sensor_addr,
   input  logic [2:0]         target_addr,
   output logic [SCORE_W-1:0] score,
   output logic               hit_pulse,
   output logic               miss_pulse,
   output logic               next_target,
   output logic               armed
);

   localparam int DW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CW = (COOLDOWN_CYCLES < 2) ? 1 : $clog2(COOLDOWN_CYCLES + 1);
   localparam logic [DW-1:0]      DEB_LAST  = DW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]      COOL_LAST = CW'(COOLDOWN_CYCLES - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      COOLDOWN = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   // ---------------------------------------------------------------------
   // Input path: synchroniser and debouncer
   // ---------------------------------------------------------------------
   // The 3-bit code is synchronised bit-wise; skew between bits on a change
   // is harmless because the debouncer only accepts a value that stays
   // identical for DEBOUNCE_CYCLES consecutive synchronised cycles.
   logic [2:0]    sync1_reg;
   logic [2:0]    s_sync_reg;
   logic [2:0]    cand_reg;      // s_sync as seen on the previous cycle
   logic [2:0]    deb_reg;
   logic [2:0]    deb_prev_reg;
   logic [DW-1:0] deb_cnt_reg;
   logic [DW-1:0] deb_cnt_next;
   logic [2:0]    deb_next;

   always_comb begin
      deb_cnt_next = '0;
      deb_next     = deb_reg;
      if (s_sync_reg != deb_reg) begin
         // Same value as last cycle extends the run, anything else restarts it.
         if (s_sync_reg == cand_reg)
            deb_cnt_next = deb_cnt_reg + DW'(1);
         else
            deb_cnt_next = DW'(1);
         if (deb_cnt_next == DEB_LAST) begin
            deb_next     = s_sync_reg;
            deb_cnt_next = '0;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         sync1_reg    <= '0;
         s_sync_reg   <= '0;
         cand_reg     <= '0;
         deb_reg      <= '0;
         deb_prev_reg <= '0;
         deb_cnt_reg  <= '0;
      end else begin
         sync1_reg    <= sensor_addr;
         s_sync_reg   <= sync1_reg;
         cand_reg     <= s_sync_reg;
         deb_reg      <= deb_next;
         deb_prev_reg <= deb_reg;
         deb_cnt_reg  <= deb_cnt_next;
      end
   end

   // Only a press (0 -> nonzero) is a strike; sliding between boxes or
   // letting go never scores.
   logic strike_event;
   assign strike_event = (deb_prev_reg == 3'd0) && (deb_reg != 3'd0);

   // ---------------------------------------------------------------------
   // Round control and scoring FSM
   // ---------------------------------------------------------------------
   logic               ga_prev_reg;
   logic               ga_rise;
   state_t             state_reg,  state_next;
   logic [CW-1:0]      cool_reg,   cool_next;
   logic [SCORE_W-1:0] score_reg,  score_next;
   logic               hit_reg,    hit_next;
   logic               miss_reg,   miss_next;
   logic               armed_reg;

   assign ga_rise = game_active && !ga_prev_reg;

   always_comb begin
      state_next = state_reg;
      cool_next  = cool_reg;
      score_next = score_reg;
      hit_next   = 1'b0;
      miss_next  = 1'b0;

      if (!game_active) begin
         // Leaving the round beats everything, including a same-cycle strike.
         state_next = IDLE;
         cool_next  = '0;
      end else begin
         if (ga_rise)
            score_next = '0;

         case (state_reg)
            IDLE: begin
               // The clearing cycle does not arm; arming follows one cycle later.
               if (!ga_rise)
                  state_next = ARMED;
            end
            ARMED: begin
               if (strike_event && (target_addr != 3'd0)) begin
                  if (deb_reg == target_addr) begin
                     hit_next = 1'b1;
                     if (score_reg != SCORE_MAX)
                        score_next = score_reg + SCORE_W'(1);
                  end else begin
                     miss_next = 1'b1;
                     if (score_reg != '0)
                        score_next = score_reg - SCORE_W'(1);
                  end
                  state_next = COOLDOWN;
                  cool_next  = '0;
               end
            end
            COOLDOWN: begin
               if (cool_reg == COOL_LAST) begin
                  state_next = RELEASE;
                  cool_next  = '0;
               end else begin
                  cool_next = cool_reg + CW'(1);
               end
            end
            RELEASE: begin
               // A box still held down must be let go before the next strike.
               if (deb_reg == 3'd0)
                  state_next = ARMED;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         ga_prev_reg <= 1'b0;
         state_reg   <= IDLE;
         cool_reg    <= '0;
         score_reg   <= '0;
         hit_reg     <= 1'b0;
         miss_reg    <= 1'b0;
         armed_reg   <= 1'b0;
      end else begin
         ga_prev_reg <= game_active;
         state_reg   <= state_next;
         cool_reg    <= cool_next;
         score_reg   <= score_next;
         hit_reg     <= hit_next;
         miss_reg    <= miss_next;
         armed_reg   <= (state_next == ARMED);
      end
   end

   assign score       = score_reg;
   assign hit_pulse   = hit_reg;
   assign miss_pulse  = miss_reg;
   assign next_target = hit_reg;
   assign armed       = armed_reg;

endmodule

// File: tb/tb_whack_hit_scorer.sv
// -----------------------------------------------------------------------------
// tb_whack_hit_scorer
//
// Directed bench for whack_hit_scorer with DEBOUNCE_CYCLES=4,
// COOLDOWN_CYCLES=8, SCORE_W=4. Inputs are driven 1 ns after a rising edge
// and outputs are sampled at the same point, so a value driven after edge E
// is first captured at edge E+1. A correct strike therefore pulses 7 edges
// after the sensor change (2 synchroniser + 4 debounce + 1 registered output).
// -----------------------------------------------------------------------------
module tb_whack_hit_scorer;

   logic       CLOCK_50 = 1'b0;
   logic       resetn;
   logic       game_active;
   logic [2:0] sensor_addr;
   logic [2:0] target_addr;
   logic [3:0] score;
   logic       hit_pulse;
   logic       miss_pulse;
   logic       next_target;
   logic       armed;

   int checks = 0;
   int errors = 0;
   int hit_cnt, miss_cnt, next_cnt;
   int both_total = 0;
   int next_mismatch = 0;

   whack_hit_scorer #(
      .DEBOUNCE_CYCLES(4),
      .COOLDOWN_CYCLES(8),
      .SCORE_W        (4)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .resetn     (resetn),
      .game_active(game_active),
      .sensor_addr(sensor_addr),
      .target_addr(target_addr),
      .score      (score),
      .hit_pulse  (hit_pulse),
      .miss_pulse (miss_pulse),
      .next_target(next_target),
      .armed      (armed)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
      if (obs === exp)
         $display("check %-16s observed=%0d", tag, obs);
   endtask

   task automatic clear_counts();
      hit_cnt  = 0;
      miss_cnt = 0;
      next_cnt = 0;
   endtask

   // Advance n cycles, tallying every pulse seen.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLOCK_50);
         #1;
         if (hit_pulse === 1'b1)  hit_cnt++;
         if (miss_pulse === 1'b1) miss_cnt++;
         if (next_target === 1'b1) next_cnt++;
         if (hit_pulse === 1'b1 && miss_pulse === 1'b1) both_total++;
         if (next_target !== hit_pulse) next_mismatch++;
      end
   endtask

   // Press a box for 10 cycles, release and let the FSM re-arm.
   task automatic strike(input logic [2:0] box);
      sensor_addr = box;
      run(10);
      sensor_addr = 3'd0;
      run(20);
   endtask

   initial begin
      resetn      = 1'b0;
      game_active = 1'b0;
      sensor_addr = 3'd0;
      target_addr = 3'd0;
      clear_counts();
      run(3);
      chk("rst_score", score, 0);
      chk("rst_hit", hit_pulse, 0);
      chk("rst_miss", miss_pulse, 0);
      chk("rst_next", next_target, 0);
      chk("rst_armed", armed, 0);

      // Start a round: first cycle clears, second cycle arms.
      resetn      = 1'b1;
      game_active = 1'b1;
      target_addr = 3'd3;
      run(1);
      chk("start_noarm", armed, 0);
      run(1);
      chk("start_armed", armed, 1);

      // Correct hit with exact latency.
      clear_counts();
      sensor_addr = 3'd3;
      run(6);
      chk("hit_early", hit_cnt, 0);
      run(1);
      chk("hit_pulse", hit_pulse, 1);
      chk("hit_next", next_target, 1);
      chk("hit_nomiss", miss_pulse, 0);
      chk("hit_score", score, 1);
      run(1);
      chk("hit_width", hit_pulse, 0);
      sensor_addr = 3'd0;
      run(20);
      chk("rearm", armed, 1);

      // Glitch of 3 cycles, then single-cycle bounce.
      clear_counts();
      sensor_addr = 3'd5;
      run(3);
      sensor_addr = 3'd0;
      run(4);
      chk("glitch_deb", dut.deb_reg, 0);
      for (int i = 0; i < 10; i++) begin
         sensor_addr = 3'd5;
         run(1);
         sensor_addr = 3'd0;
         run(1);
      end
      run(10);
      chk("bounce_deb", dut.deb_reg, 0);
      chk("bounce_hits", hit_cnt, 0);
      chk("bounce_miss", miss_cnt, 0);
      chk("bounce_score", score, 1);

      // Misses: 1 -> 0, then floor at 0 with pulse still firing.
      target_addr = 3'd2;
      clear_counts();
      strike(3'd4);
      chk("miss1_cnt", miss_cnt, 1);
      chk("miss1_score", score, 0);
      clear_counts();
      strike(3'd4);
      chk("miss_floor_cnt", miss_cnt, 1);
      chk("miss_floor_hit", hit_cnt, 0);
      chk("miss_floor_sc", score, 0);

      // Fill to 15 and saturate.
      target_addr = 3'd3;
      clear_counts();
      for (int i = 0; i < 15; i++) strike(3'd3);
      chk("fill_hits", hit_cnt, 15);
      chk("fill_score", score, 15);
      clear_counts();
      strike(3'd3);
      chk("sat_hit", hit_cnt, 1);
      chk("sat_score", score, 15);

      // Round control: drop holds score, rise clears it without arming.
      game_active = 1'b0;
      run(2);
      chk("drop_armed", armed, 0);
      chk("drop_score", score, 15);
      game_active = 1'b1;
      run(1);
      chk("rise_clear", score, 0);
      chk("rise_noarm", armed, 0);
      run(1);
      chk("rise_armed", armed, 1);

      // Holding a box scores once.
      clear_counts();
      sensor_addr = 3'd3;
      run(40);
      chk("hold_hits", hit_cnt, 1);
      chk("hold_score", score, 1);
      sensor_addr = 3'd0;
      run(20);
      chk("hold_rearm", armed, 1);
      clear_counts();
      strike(3'd3);
      chk("second_hit", hit_cnt, 1);
      chk("second_score", score, 2);

      // Release and re-press inside cooldown: second press is discarded.
      clear_counts();
      sensor_addr = 3'd3;
      run(4);
      sensor_addr = 3'd0;
      run(4);
      sensor_addr = 3'd3;
      run(7);
      chk("cd_deb_up", dut.deb_reg, 3);
      chk("cd_not_armed", armed, 0);
      run(5);
      sensor_addr = 3'd0;
      run(20);
      chk("cd_hits", hit_cnt, 1);
      chk("cd_miss", miss_cnt, 0);
      chk("cd_score", score, 3);
      chk("cd_rearm", armed, 1);

      // game_active falls in the event cycle: no pulse, no score change.
      clear_counts();
      sensor_addr = 3'd3;
      run(6);
      game_active = 1'b0;
      run(1);
      chk("gdrop_hit", hit_pulse, 0);
      chk("gdrop_armed", armed, 0);
      sensor_addr = 3'd0;
      run(10);
      chk("gdrop_hits", hit_cnt, 0);
      chk("gdrop_miss", miss_cnt, 0);
      chk("gdrop_score", score, 3);

      // Reset in the middle of cooldown.
      game_active = 1'b1;
      run(2);
      chk("r2_clear", score, 0);
      chk("r2_armed", armed, 1);
      clear_counts();
      sensor_addr = 3'd3;
      run(7);
      chk("r2_hit", hit_pulse, 1);
      chk("r2_score", score, 1);
      run(3);
      sensor_addr = 3'd0;
      resetn      = 1'b0;
      run(1);
      chk("mrst_score", score, 0);
      chk("mrst_armed", armed, 0);
      chk("mrst_hit", hit_pulse, 0);
      chk("mrst_miss", miss_pulse, 0);
      chk("mrst_deb", dut.deb_reg, 0);
      chk("mrst_hits", hit_cnt, 1);
      resetn = 1'b1;
      run(1);
      chk("post_noarm", armed, 0);
      run(1);
      chk("post_armed", armed, 1);
      run(10);

      chk("never_both", both_total, 0);
      chk("next_eq_hit", next_mismatch, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
